// File: rtl/dma_priority_arbiter.sv
// Priority resolver and HRQ/HLDA bus-request sequencer for a 4-channel 8237A-style DMA controller.
// Picks one channel per bus tenure (fixed or rotating priority) and holds the grant until service completes.
module dma_priority_arbiter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] commandReg,
    input  logic [7:0] requestReg,
    input  logic [7:0] maskReg,
    input  logic [3:0] DREQ,
    input  logic       HLDA,
    input  logic       svcDone,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic       grantValid,
    output logic [1:0] grantCh,
    output logic [3:0] reqPending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] dreq_q;
    logic [3:0] eff;
    logic [3:0] dack;
    logic [1:0] last_ch;
    logic [1:0] base;
    logic [1:0] idx;
    logic [1:0] winner;
    logic       found;
    logic       hrq_next;
    logic       valid_next;
    logic       unused_bits;

    assign unused_bits = ^{commandReg[5], commandReg[3], commandReg[1:0],
                           requestReg[7:4], maskReg[7:4]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dreq_q <= 4'h0;
        end else begin
            dreq_q <= DREQ;
        end
    end

    // Software requests bypass the mask; hardware requests are polarity-corrected first.
    assign eff        = ((dreq_q ^ {4{commandReg[6]}}) & ~maskReg[3:0]) | requestReg[3:0];
    assign reqPending = eff;

    // Scan upward from the highest-priority channel; rotating mode starts after the last serviced one.
    always_comb begin
        base   = commandReg[4] ? (last_ch + 2'd1) : 2'd0;
        idx    = 2'd0;
        winner = 2'd0;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && eff[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if ((eff != 4'h0) && !commandReg[2]) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (HLDA) begin
                    state_next = found ? GRANT : RELEASE;
                end
            end
            GRANT: begin
                if (svcDone) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!HLDA) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        hrq_next   = (state_next == REQ) || (state_next == GRANT);
        valid_next = (state_next == GRANT);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            HRQ        <= 1'b0;
            grantValid <= 1'b0;
            grantCh    <= 2'd0;
            last_ch    <= 2'd3;
        end else begin
            state      <= state_next;
            HRQ        <= hrq_next;
            grantValid <= valid_next;
            if ((state == REQ) && HLDA && found) begin
                grantCh <= winner;
            end
            if ((state == GRANT) && svcDone) begin
                last_ch <= grantCh;
            end
        end
    end

    assign dack = grantValid ? (4'b0001 << grantCh) : 4'b0000;
    assign DACK = commandReg[7] ? dack : ~dack;

endmodule
